sram_ctrl_256x22: RTL and testbench

Synchronous initiator for the 256-word x 22-bit single-port register-file SRAM (row/column addressed: RA[5:0], CA[1:0], active-low NCE/NWRT). It accepts one read or write request per cycle over a valid/ready interface and drives the SRAM pins from registers. It captures DO one cycle after the SRAM sampling edge and returns read data, in order, through a 4-entry response FIFO with backpressure. It sits between the datapath/DMA logic and the RAM macro, and is the only block allowed to drive the macro's inputs.

---
 rtl/sram_pkg.sv | 35 +++
 rtl/sram_ctrl_256x22_if.sv | 24 ++
 rtl/sram_rsp_fifo.sv | 49 ++++
 rtl/sram_ctrl_256x22.sv | 89 ++++++++
 tb/tb_sram_ctrl_256x22.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared widths, address split and request/response payloads for the 256x22 SRAM controller.
package sram_pkg;

  localparam int unsigned DATA_W    = 22;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned RA_W      = 6;
  localparam int unsigned CA_W      = 2;
  localparam int unsigned RSP_DEPTH = 4;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned PTR_W     = 2;

  typedef struct packed {
    logic [RA_W-1:0] ra;
    logic [CA_W-1:0] ca;
  } macro_addr_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  // Word address -> macro row/column: upper bits select the row, low bits the column.
  function automatic macro_addr_t split_addr(input logic [ADDR_W-1:0] addr);
    macro_addr_t m;
    m.ra = addr[ADDR_W-1:CA_W];
    m.ca = addr[CA_W-1:0];
    return m;
  endfunction

endpackage

// File: rtl/sram_ctrl_256x22_if.sv
// Request/response handshake bundle between the datapath and the SRAM controller.
interface sram_ctrl_256x22_if;
  import sram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO; head entry is presented directly on rdata.
module sram_rsp_fifo
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(RSP_DEPTH));
  assign empty   = (count == CNT_W'(0));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage and pointers; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RSP_DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_ctrl_256x22.sv
// Initiator for the 256x22 register-file SRAM: registered pins, read-tag pipe, credit-limited response FIFO.
module sram_ctrl_256x22
  import sram_pkg::*;
(
  input  logic              CLK,
  input  logic              NRST,
  sram_ctrl_256x22_if.slave bus,
  output logic              NCE,
  output logic              NWRT,
  output logic [RA_W-1:0]   RA,
  output logic [CA_W-1:0]   CA,
  output logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] DO
);

  req_t             req;
  macro_addr_t      maddr;
  logic [CNT_W-1:0] credit_q;
  logic [1:0]       rd_pipe_q;
  logic             accept;
  logic             rd_accept;
  logic             push;
  logic             pop;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;

  assign req       = {bus.req_wr, bus.req_addr, bus.req_wdata};
  assign maddr     = split_addr(req.addr);
  assign pop       = bus.rsp_valid & bus.rsp_ready;
  assign bus.rsp_valid = ~fifo_empty;
  // Ready depends only on registered credit and the consumer's pop, never on req_valid.
  assign bus.req_ready = (credit_q < CNT_W'(RSP_DEPTH)) | pop;
  assign accept    = bus.req_valid & bus.req_ready;
  assign rd_accept = accept & ~req.wr;
  assign push      = rd_pipe_q[1];
  assign fifo_push = push & (~fifo_full | pop);

  // Macro pin registers; address and data hold while idle to avoid toggling.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      NCE  <= 1'b1;
      NWRT <= 1'b1;
      RA   <= '0;
      CA   <= '0;
      DIN  <= '0;
    end else if (accept) begin
      NCE  <= 1'b0;
      NWRT <= ~req.wr;
      RA   <= maddr.ra;
      CA   <= maddr.ca;
      if (req.wr) DIN <= req.wdata;
    end else begin
      NCE  <= 1'b1;
      NWRT <= 1'b1;
    end
  end

  // Read tag: stage 0 = pins driven, stage 1 = macro sampled, DO captured on the next edge.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) rd_pipe_q <= '0;
    else       rd_pipe_q <= {rd_pipe_q[0], rd_accept};
  end

  // Outstanding reads (in pipe plus queued), bounded by the FIFO depth.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      credit_q <= '0;
    end else begin
      case ({rd_accept, pop})
        2'b10:   credit_q <= credit_q + CNT_W'(1);
        2'b01:   credit_q <= credit_q - CNT_W'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

  sram_rsp_fifo u_fifo (
    .clk   (CLK),
    .rst_n (NRST),
    .push  (fifo_push),
    .pop   (pop),
    .wdata (DO),
    .rdata (bus.rsp_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_ctrl_256x22.sv
// Bench for sram_ctrl_256x22: macro model, queue-based reference, vector table and directed corners.
module tb_sram_ctrl_256x22;
  import sram_pkg::*;

  logic        CLK = 1'b0;
  logic        NRST;
  logic        NCE, NWRT;
  logic [5:0]  RA;
  logic [1:0]  CA;
  logic [21:0] DIN, DO;

  always #5 CLK = ~CLK;

  sram_ctrl_256x22_if bus();

  sram_ctrl_256x22 dut (
    .CLK(CLK), .NRST(NRST), .bus(bus.slave),
    .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA), .DIN(DIN), .DO(DO)
  );

  // Behavioural macro: samples pins on posedge, commits writes, presents read data after the edge.
  logic [21:0] macro_mem [256];
  always @(posedge CLK) begin
    if (NCE === 1'b0) begin
      if (NWRT === 1'b0) macro_mem[{RA, CA}] <= DIN;
      else               DO <= macro_mem[{RA, CA}];
    end
  end

  // Reference: memory contents in program order plus a queue of expected responses.
  typedef struct { logic [21:0] data; int ready_cyc; } exp_t;
  logic [21:0] ref_mem [256];
  exp_t        expq [$];
  int          cyc;
  logic        exp_nce, exp_nwrt;
  logic [7:0]  exp_addr;
  logic [21:0] exp_din;
  int          checks, failures;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    exp_nce = 1'b1; exp_nwrt = 1'b1; exp_addr = '0; exp_din = '0;
  endtask

  // One cycle: drive, check handshake against model, update model, check pins after the edge.
  task automatic step(input logic v, input logic wr, input logic [7:0] a, input logic [21:0] wd,
                      input logic rr, output logic acc, output logic g_ready,
                      output logic g_valid, output logic [21:0] g_data);
    logic ev, er;
    exp_t e;
    @(negedge CLK);
    bus.req_valid = v; bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = wd; bus.rsp_ready = rr;
    #1;
    ev = (expq.size() > 0) && (cyc >= expq[0].ready_cyc);
    er = (expq.size() < int'(RSP_DEPTH)) || (ev && rr);
    g_ready = bus.req_ready; g_valid = bus.rsp_valid; g_data = bus.rsp_rdata;
    chk("req_ready", 32'(g_ready), 32'(er));
    chk("rsp_valid", 32'(g_valid), 32'(ev));
    if (ev) chk("rsp_rdata", 32'(g_data), 32'(expq[0].data));
    if (ev && rr) void'(expq.pop_front());
    acc = v & g_ready;
    if (acc) begin
      exp_nce = 1'b0; exp_nwrt = ~wr; exp_addr = a;
      if (wr) begin
        exp_din = wd; ref_mem[a] = wd;
      end else begin
        e.data = ref_mem[a]; e.ready_cyc = cyc + 3;
        expq.push_back(e);
      end
    end else begin
      exp_nce = 1'b1; exp_nwrt = 1'b1;
    end
    @(posedge CLK); #1; cyc++;
    chk("NCE", 32'(NCE), 32'(exp_nce));
    chk("NWRT", 32'(NWRT), 32'(exp_nwrt));
    chk("RA_CA", 32'({RA, CA}), 32'(exp_addr));
    chk("DIN", 32'(DIN), 32'(exp_din));
  endtask

  // Captures must never find the FIFO full without a simultaneous pop.
  always @(posedge CLK) begin
    if (NRST === 1'b1 && dut.push && dut.fifo_full && !dut.pop) begin
      failures++;
      $display("FAIL fifo_overflow push while full");
    end
  end

  typedef struct {
    logic v, wr; logic [7:0] a; logic [21:0] wd; logic rr;
    logic e_ready, e_valid; logic [21:0] e_data; logic e_nce, e_nwrt;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic acc, gr, gv;
    logic [21:0] gd;
    logic [5:0]  s_ra;
    logic [1:0]  s_ca;
    logic [21:0] s_din;
    int issued, pops, n, found;

    checks = 0; failures = 0; cyc = 0;
    for (int i = 0; i < 256; i++) begin macro_mem[i] = '0; ref_mem[i] = '0; end
    DO = '0;
    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 1;
    model_reset();
    NRST = 1'b0;
    #22;
    chk("rst_NCE", 32'(NCE), 1); chk("rst_NWRT", 32'(NWRT), 1);
    chk("rst_RA_CA", 32'({RA, CA}), 0); chk("rst_DIN", 32'(DIN), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0); chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    @(negedge CLK); NRST = 1'b1;

    // Writes to both address extremes then reads back; responses two edges after accept.
    tbl[0] = '{1'b1, 1'b1, 8'h00, 22'h2AAAAA, 1'b1, 1'b1, 1'b0, 22'h0,      1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'hFF, 22'h155555, 1'b1, 1'b1, 1'b0, 22'h0,      1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 22'h0,      1'b1, 1'b1, 1'b0, 22'h0,      1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 8'hFF, 22'h0,      1'b1, 1'b1, 1'b0, 22'h0,      1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'hFF, 22'h0,      1'b1, 1'b1, 1'b0, 22'h0,      1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 8'hFF, 22'h0,      1'b1, 1'b1, 1'b1, 22'h2AAAAA, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 8'hFF, 22'h0,      1'b1, 1'b1, 1'b1, 22'h155555, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 8'hFF, 22'h0,      1'b1, 1'b1, 1'b0, 22'h0,      1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].rr, acc, gr, gv, gd);
      chk($sformatf("tbl%0d_ready", i), 32'(gr), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_valid", i), 32'(gv), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_rdata", i), 32'(gd), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_nce", i), 32'(NCE), 32'(tbl[i].e_nce));
      chk($sformatf("tbl%0d_nwrt", i), 32'(NWRT), 32'(tbl[i].e_nwrt));
    end

    // Write then read the same address on the next cycle.
    step(1, 1, 8'h47, 22'h3FFFFF, 1, acc, gr, gv, gd);
    step(1, 0, 8'h47, 22'h0, 1, acc, gr, gv, gd);
    chk("raw_RA", 32'(RA), 32'h11); chk("raw_CA", 32'(CA), 32'h3);
    found = 0;
    for (int i = 1; i <= 5 && found == 0; i++) begin
      step(0, 0, 8'h47, 22'h0, 1, acc, gr, gv, gd);
      if (gv) begin found = i; chk("raw_rdata", 32'(gd), 32'h3FFFFF); end
    end
    chk("raw_latency", 32'(found), 3);

    // Backpressure: six reads with the consumer stalled.
    for (int i = 0; i < 6; i++) step(1, 1, 8'(8'h40 + i), 22'($urandom), 1, acc, gr, gv, gd);
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'(8'h40 + issued), 22'h0, 0, acc, gr, gv, gd);
      if (acc) issued++;
    end
    chk("bp_issued_stalled", 32'(issued), 4);
    chk("bp_ready_low", 32'(gr), 0);
    pops = 0;
    for (int i = 0; i < 20 && (issued < 6 || pops < 6); i++) begin
      step(issued < 6, 0, 8'(8'h40 + issued), 22'h0, 1, acc, gr, gv, gd);
      if (gv) pops++;
      if (acc) issued++;
    end
    chk("bp_issued_total", 32'(issued), 6);
    chk("bp_pops_total", 32'(pops), 6);

    // FIFO full of reads; a write gets in on the pop cycle and yields no response.
    for (int i = 0; i < 4; i++) step(1, 0, 8'(i), 22'h0, 0, acc, gr, gv, gd);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h0, 22'h0, 0, acc, gr, gv, gd);
    step(1, 1, 8'h80, 22'h123456, 0, acc, gr, gv, gd);
    chk("full_write_blocked", 32'(acc), 0);
    step(1, 1, 8'h80, 22'h123456, 1, acc, gr, gv, gd);
    chk("full_write_acc", 32'(acc), 1);
    chk("full_write_NCE", 32'(NCE), 0); chk("full_write_NWRT", 32'(NWRT), 0);
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 8'h0, 22'h0, 1, acc, gr, gv, gd);
      if (gv) pops++;
    end
    chk("full_write_no_rsp", 32'(pops), 3);

    // Reset one cycle after a read accept.
    step(1, 0, 8'h47, 22'h0, 1, acc, gr, gv, gd);
    @(negedge CLK);
    bus.req_valid = 0; NRST = 1'b0;
    #1;
    chk("mid_rst_NCE", 32'(NCE), 1); chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK); NRST = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 8'h0, 22'h0, 1, acc, gr, gv, gd);
    chk("post_rst_ready", 32'(gr), 1);

    // Idle after a write: pins inactive, address/data held.
    step(1, 1, 8'h9C, 22'h2B3C4D, 1, acc, gr, gv, gd);
    s_ra = RA; s_ca = CA; s_din = DIN;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'($urandom), 22'($urandom), 1, acc, gr, gv, gd);
      if (NCE !== 1'b1 || NWRT !== 1'b1 || RA !== s_ra || CA !== s_ca || DIN !== s_din) n++;
    end
    chk("idle_hold_violations", 32'(n), 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 2) != 0,
           ($urandom % 2) ? 8'($urandom % 16) : 8'($urandom),
           22'($urandom), ($urandom % 3) != 0, acc, gr, gv, gd);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 8'h0, 22'h0, 1, acc, gr, gv, gd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
